// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the instruction-fetch controller: widths, opcode
// constants, the controller state encoding and the fetch-queue entry layout.
package fetch_sequencer_pkg;

  localparam int PC_W   = 4;
  localparam int INST_W = 16;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADDI = 4'h1;
  localparam logic [3:0] OP_OUT  = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_STEP,
    ST_DRAIN,
    ST_HALTED
  } fetch_state_t;

  // One queued instruction together with the address it came from.
  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] data;
  } fetch_entry_t;

  // Sequential successor address; wraps naturally at the top of the ROM.
  function automatic logic [PC_W-1:0] pc_next(input logic [PC_W-1:0] pc);
    return pc + PC_W'(1);
  endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// ROM-side and decode-side signals of the fetch controller. The master
// modport is the fetch controller; the slave modport is the ROM plus the
// decode stage.
interface fetch_sequencer_if;
  import fetch_sequencer_pkg::*;

  logic [PC_W-1:0]   rom_addr;
  logic [INST_W-1:0] rom_data;
  logic              inst_valid;
  logic              inst_ready;
  logic [INST_W-1:0] inst_data;
  logic [PC_W-1:0]   inst_pc;

  modport master (
    output rom_addr,
    input  rom_data,
    output inst_valid,
    input  inst_ready,
    output inst_data,
    output inst_pc
  );

  modport slave (
    input  rom_addr,
    output rom_data,
    input  inst_valid,
    output inst_ready,
    input  inst_data,
    input  inst_pc
  );

endinterface

// File: rtl/fetch_queue.sv
// Two-entry FIFO holding fetched instructions. Slot 0 is always the head so
// the decode-facing outputs come straight from a register. Flush empties the
// queue regardless of push/pop in the same cycle.
module fetch_queue
  import fetch_sequencer_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  fetch_entry_t push_entry,
  input  logic         pop,
  input  logic         flush,
  output logic [1:0]   count,
  output logic         head_valid,
  output fetch_entry_t head
);

  fetch_entry_t slot0;
  fetch_entry_t slot1;
  logic [1:0]   cnt;
  logic         do_pop;

  assign do_pop = pop && (cnt != 2'd0);

  // Slot/count update: push fills the first free slot, pop shifts slot 1 down.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot0 <= '0;
      slot1 <= '0;
      cnt   <= 2'd0;
    end else if (flush) begin
      cnt <= 2'd0;
    end else begin
      case ({push, do_pop})
        2'b10: begin
          if (cnt != 2'd2) begin
            if (cnt == 2'd0) slot0 <= push_entry;
            else             slot1 <= push_entry;
            cnt <= cnt + 2'd1;
          end
        end
        2'b01: begin
          slot0 <= slot1;
          cnt   <= cnt - 2'd1;
        end
        2'b11: begin
          if (cnt == 2'd1) begin
            slot0 <= push_entry;
          end else begin
            slot0 <= slot1;
            slot1 <= push_entry;
          end
        end
        default: ;
      endcase
    end
  end

  assign count      = cnt;
  assign head_valid = (cnt != 2'd0);
  assign head       = slot0;

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, addresses the program ROM and
// feeds a 2-entry queue toward decode. Supports free-run, single-step,
// redirect and drain-to-halt.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            run,
  input  logic            step,
  input  logic            halt_req,
  input  logic            redirect_valid,
  input  logic [PC_W-1:0] redirect_pc,
  output logic            halted,
  output logic            wrapped,
  fetch_sequencer_if.master bus
);

  fetch_state_t    state;
  fetch_state_t    next_state;
  logic [PC_W-1:0] pc;
  logic [1:0]      count;
  logic            head_valid;
  fetch_entry_t    head;
  fetch_entry_t    push_entry;
  logic            pop;
  logic            redirect_act;
  logic            fetch;

  assign pop        = head_valid && bus.inst_ready;
  assign push_entry = '{pc: pc, data: bus.rom_data};

  // Decide redirect, fetch and the next controller state for this cycle.
  always_comb begin
    next_state   = state;
    redirect_act = 1'b0;
    fetch        = 1'b0;

    if (state != ST_DRAIN && state != ST_HALTED) begin
      redirect_act = redirect_valid;
    end

    if ((state == ST_RUN || state == ST_STEP) && !redirect_act &&
        (count != 2'd2 || pop)) begin
      fetch = 1'b1;
    end

    case (state)
      ST_IDLE: begin
        if (halt_req)  next_state = ST_DRAIN;
        else if (run)  next_state = ST_RUN;
        else if (step) next_state = ST_STEP;
      end
      ST_RUN: begin
        if (halt_req)  next_state = ST_DRAIN;
        else if (!run) next_state = ST_IDLE;
      end
      ST_STEP: begin
        if (halt_req)   next_state = ST_DRAIN;
        else if (fetch) next_state = ST_IDLE;
      end
      ST_DRAIN: begin
        if (count == 2'd0) next_state = ST_HALTED;
      end
      ST_HALTED: next_state = ST_HALTED;
      default:   next_state = ST_IDLE;
    endcase
  end

  // Controller state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= next_state;
  end

  // Program counter and the registered wrap pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc      <= '0;
      wrapped <= 1'b0;
    end else begin
      wrapped <= fetch && (pc == {PC_W{1'b1}});
      if (redirect_act) pc <= redirect_pc;
      else if (fetch)   pc <= pc_next(pc);
    end
  end

  fetch_queue u_queue (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (fetch),
    .push_entry (push_entry),
    .pop        (pop),
    .flush      (redirect_act),
    .count      (count),
    .head_valid (head_valid),
    .head       (head)
  );

  assign bus.rom_addr   = pc;
  assign bus.inst_valid = head_valid;
  assign bus.inst_data  = head.data;
  assign bus.inst_pc    = head.pc;
  assign halted         = (state == ST_HALTED);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Testbench for fetch_sequencer: directed scenarios plus randomized traffic,
// checked every cycle against a queue-based reference model.
module tb_fetch_sequencer;
  import fetch_sequencer_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       run, step, halt_req, redirect_valid;
  logic [3:0] redirect_pc;
  logic       halted, wrapped;

  fetch_sequencer_if bus();

  logic [15:0] rom [16];
  assign bus.rom_data = rom[bus.rom_addr];

  always #5 clk = ~clk;

  fetch_sequencer dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .run            (run),
    .step           (step),
    .halt_req       (halt_req),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halted         (halted),
    .wrapped        (wrapped),
    .bus            (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  localparam int M_IDLE   = 0;
  localparam int M_RUN    = 1;
  localparam int M_STEP   = 2;
  localparam int M_DRAIN  = 3;
  localparam int M_HALTED = 4;

  int          m_state;
  int          m_pc;
  bit          m_wrapped;
  logic [19:0] mq[$];

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    logic [19:0] h;
    check_output("rom_addr", 32'(bus.rom_addr), 32'(m_pc));
    check_output("inst_valid", 32'(bus.inst_valid), 32'(mq.size() != 0));
    if (mq.size() != 0) begin
      h = mq[0];
      check_output("inst_pc", 32'(bus.inst_pc), 32'(h[19:16]));
      check_output("inst_data", 32'(bus.inst_data), 32'(h[15:0]));
    end
    check_output("halted", 32'(halted), 32'(m_state == M_HALTED));
    check_output("wrapped", 32'(wrapped), 32'(m_wrapped));
  endtask

  task automatic model_reset();
    m_state   = M_IDLE;
    m_pc      = 0;
    m_wrapped = 0;
    mq.delete();
  endtask

  // One clock cycle: drive inputs at the falling edge, advance the model by
  // the behavioural rules, then compare after the next falling edge.
  task automatic apply_stimulus(input bit r, input bit s, input bit h, input bit rdy,
                                input bit rv, input logic [3:0] rpc);
    bit do_pop, redir, do_fetch;
    int old_size;
    run = r; step = s; halt_req = h; bus.inst_ready = rdy;
    redirect_valid = rv; redirect_pc = rpc;

    old_size = mq.size();
    do_pop   = (old_size != 0) && rdy;
    redir    = rv && (m_state != M_DRAIN) && (m_state != M_HALTED);
    do_fetch = (m_state == M_RUN || m_state == M_STEP) && !redir && (old_size < 2 || do_pop);

    if (do_pop) void'(mq.pop_front());
    if (redir) mq.delete();
    if (do_fetch) mq.push_back({4'(m_pc), rom[m_pc]});
    m_wrapped = do_fetch && (m_pc == 15);
    if (redir) m_pc = int'(rpc);
    else if (do_fetch) m_pc = (m_pc + 1) % 16;

    case (m_state)
      M_IDLE:  m_state = h ? M_DRAIN : r ? M_RUN : s ? M_STEP : M_IDLE;
      M_RUN:   m_state = h ? M_DRAIN : !r ? M_IDLE : M_RUN;
      M_STEP:  m_state = h ? M_DRAIN : do_fetch ? M_IDLE : M_STEP;
      M_DRAIN: m_state = (old_size == 0) ? M_HALTED : M_DRAIN;
      default: m_state = M_HALTED;
    endcase

    @(posedge clk);
    @(negedge clk);
    check_model();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    run = 0; step = 0; halt_req = 0; redirect_valid = 0; redirect_pc = '0;
    bus.inst_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    check_model();
    check_output("reset_inst_data", 32'(bus.inst_data), 32'h0);
    check_output("reset_inst_pc", 32'(bus.inst_pc), 32'h0);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rom[i] = 16'($urandom);

    $display("[TB] free-run with ready high, across the PC wrap");
    do_reset();
    apply_stimulus(1, 0, 0, 1, 0, 4'd0);
    check_output("start_latency_1", 32'(bus.inst_valid), 32'h0);
    apply_stimulus(1, 0, 0, 1, 0, 4'd0);
    check_output("start_latency_2", 32'(bus.inst_valid), 32'h1);
    check_output("first_pc", 32'(bus.inst_pc), 32'h0);
    for (int i = 0; i < 20; i++) apply_stimulus(1, 0, 0, 1, 0, 4'd0);
    apply_stimulus(0, 0, 0, 1, 0, 4'd0);
    for (int i = 0; i < 3; i++) apply_stimulus(0, 0, 0, 1, 0, 4'd0);

    $display("[TB] back-pressure fills the queue and stalls the PC");
    do_reset();
    for (int i = 0; i < 6; i++) apply_stimulus(1, 0, 0, 0, 0, 4'd0);
    check_output("stall_rom_addr", 32'(bus.rom_addr), 32'h2);
    for (int i = 0; i < 5; i++) apply_stimulus(1, 0, 0, 1, 0, 4'd0);
    for (int i = 0; i < 4; i++) apply_stimulus(0, 0, 0, 1, 0, 4'd0);

    $display("[TB] redirect while queue holds pc 3 and 4");
    do_reset();
    for (int i = 0; i < 3; i++) apply_stimulus(1, 0, 0, 0, 0, 4'd0);
    for (int i = 0; i < 3; i++) apply_stimulus(1, 0, 0, 1, 0, 4'd0);
    check_output("pre_redirect_head", 32'(bus.inst_pc), 32'h3);
    apply_stimulus(1, 0, 0, 1, 1, 4'd9);
    check_output("redirect_flush", 32'(bus.inst_valid), 32'h0);
    check_output("redirect_rom_addr", 32'(bus.rom_addr), 32'h9);
    apply_stimulus(1, 0, 0, 1, 0, 4'd0);
    check_output("redirect_target_pc", 32'(bus.inst_pc), 32'h9);
    for (int i = 0; i < 4; i++) apply_stimulus(0, 0, 0, 1, 0, 4'd0);

    $display("[TB] single-step three times");
    do_reset();
    for (int k = 0; k < 3; k++) begin
      apply_stimulus(0, 1, 0, 0, 0, 4'd0);
      apply_stimulus(0, 0, 0, 0, 0, 4'd0);
      check_output("step_pc", 32'(bus.inst_pc), 32'(k));
      apply_stimulus(0, 0, 0, 1, 0, 4'd0);
      apply_stimulus(0, 0, 0, 1, 0, 4'd0);
    end
    check_output("step_rom_addr", 32'(bus.rom_addr), 32'h3);

    $display("[TB] drain to halt with two entries queued");
    do_reset();
    for (int i = 0; i < 3; i++) apply_stimulus(1, 0, 0, 0, 0, 4'd0);
    apply_stimulus(1, 0, 1, 0, 0, 4'd0);
    for (int i = 0; i < 2; i++) apply_stimulus(0, 0, 0, 0, 0, 4'd0);
    for (int i = 0; i < 3; i++) apply_stimulus(0, 0, 0, 1, 0, 4'd0);
    check_output("halted_set", 32'(halted), 32'h1);
    apply_stimulus(1, 1, 0, 1, 1, 4'd7);
    apply_stimulus(1, 0, 0, 1, 0, 4'd0);
    check_output("halted_rom_addr", 32'(bus.rom_addr), 32'h2);

    $display("[TB] asynchronous reset in the middle of a run");
    do_reset();
    for (int i = 0; i < 5; i++) apply_stimulus(1, 0, 0, 0, 0, 4'd0);
    #2 rst_n = 1'b0;
    #1;
    check_output("async_inst_valid", 32'(bus.inst_valid), 32'h0);
    check_output("async_rom_addr", 32'(bus.rom_addr), 32'h0);
    check_output("async_halted", 32'(halted), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 4; i++) apply_stimulus(1, 0, 0, 1, 0, 4'd0);

    $display("[TB] randomized traffic");
    for (int blk = 0; blk < 4; blk++) begin
      do_reset();
      for (int i = 0; i < 100; i++) begin
        apply_stimulus(($urandom % 4) != 0, ($urandom % 6) == 0, ($urandom % 60) == 0,
                       ($urandom % 3) != 0, ($urandom % 10) == 0, 4'($urandom));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
